// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 message sequencer: command codes,
// ROM word layout, FSM state types and counter sizing.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;

  localparam int unsigned RS_BIT   = 8;
  localparam int unsigned ROM_LAST = 15;

  typedef enum logic [2:0] {
    PWRUP,
    INIT_WR,
    IDLE,
    CLR_WR,
    DECODE,
    CHR_WR,
    FINISH
  } lcd_state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_STROBE,
    PH_SETTLE
  } wr_phase_t;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_FUNC_SET;
      2'd1:    return LCD_DISP_ON;
      2'd2:    return LCD_CLEAR;
      default: return LCD_ENTRY;
    endcase
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/lcd_write_timer.sv
// One LCD bus write: SETUP (1 cycle), STROBE (E high), SETTLE (E low),
// with a one-cycle wr_done in the last settle cycle.
module lcd_write_timer
  import lcd_pkg::*;
#(
  parameter int unsigned T_EPULSE = 25,
  parameter int unsigned T_CMD    = 2500,
  parameter int unsigned T_CLEAR  = 100000,
  parameter int unsigned CW       = 18
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic       req_rs,
  input  logic [7:0] req_data,
  input  logic       req_long,
  output logic       wr_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  wr_phase_t       phase, phase_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            long_q, long_d;
  logic            e_d, rs_d;
  logic [7:0]      data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase    <= PH_IDLE;
      cnt      <= '0;
      long_q   <= 1'b0;
      lcd_e    <= 1'b0;
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
    end else begin
      phase    <= phase_d;
      cnt      <= cnt_d;
      long_q   <= long_d;
      lcd_e    <= e_d;
      lcd_rs   <= rs_d;
      lcd_data <= data_d;
    end
  end

  always_comb begin
    phase_d = phase;
    cnt_d   = cnt;
    long_d  = long_q;
    e_d     = lcd_e;
    rs_d    = lcd_rs;
    data_d  = lcd_data;
    wr_done = 1'b0;
    case (phase)
      PH_SETUP: begin
        phase_d = PH_STROBE;
        e_d     = 1'b1;
        cnt_d   = CW'(T_EPULSE - 1);
      end
      PH_STROBE: begin
        if (cnt == '0) begin
          phase_d = PH_SETTLE;
          e_d     = 1'b0;
          cnt_d   = long_q ? CW'(T_CLEAR - 1) : CW'(T_CMD - 1);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      PH_SETTLE: begin
        if (cnt == '0) begin
          wr_done = 1'b1;
          phase_d = PH_IDLE;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: ;
    endcase
    // A request in the final settle cycle chains straight into SETUP with no gap.
    if (req && (phase == PH_IDLE || wr_done)) begin
      phase_d = PH_SETUP;
      rs_d    = req_rs;
      data_d  = req_data;
      long_d  = req_long;
    end
  end

endmodule

// File: rtl/lcd_msg_sequencer.sv
// Top sequencer: power-up wait, fixed init commands, then clear + ROM message
// printing on each start; bus timing is delegated to lcd_write_timer.
module lcd_msg_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP  = 750000,
  parameter int unsigned T_EPULSE = 25,
  parameter int unsigned T_CMD    = 2500,
  parameter int unsigned T_CLEAR  = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] rom_index,
  input  logic [8:0] rom_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CW = cnt_width(T_PWRUP, T_CLEAR);

  lcd_state_t    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    init_idx, init_d;
  logic [3:0]    idx_d;
  logic          busy_d, done_d;

  logic          req, req_rs, req_long, wr_done;
  logic [7:0]    req_data;

  assign lcd_rw = 1'b0;

  lcd_write_timer #(
    .T_EPULSE (T_EPULSE),
    .T_CMD    (T_CMD),
    .T_CLEAR  (T_CLEAR),
    .CW       (CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_rs   (req_rs),
    .req_data (req_data),
    .req_long (req_long),
    .wr_done  (wr_done),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_data (lcd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= PWRUP;
      cnt       <= CW'(T_PWRUP - 1);
      init_idx  <= '0;
      rom_index <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      init_idx  <= init_d;
      rom_index <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    init_d   = init_idx;
    idx_d    = rom_index;
    req      = 1'b0;
    req_rs   = 1'b0;
    req_data = '0;
    case (state)
      PWRUP: begin
        if (cnt == '0) begin
          state_d  = INIT_WR;
          init_d   = '0;
          req      = 1'b1;
          req_data = init_cmd(2'd0);
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      INIT_WR: begin
        if (wr_done) begin
          if (init_idx == 2'd3) begin
            state_d = IDLE;
          end else begin
            init_d   = init_idx + 2'd1;
            req      = 1'b1;
            req_data = init_cmd(init_idx + 2'd1);
          end
        end
      end
      IDLE: begin
        if (start) begin
          state_d  = CLR_WR;
          idx_d    = '0;
          req      = 1'b1;
          req_data = LCD_CLEAR;
        end
      end
      CLR_WR: begin
        if (wr_done) state_d = DECODE;
      end
      DECODE: begin
        if (rom_data[RS_BIT]) begin
          state_d  = CHR_WR;
          req      = 1'b1;
          req_rs   = 1'b1;
          req_data = rom_data[7:0];
        end else begin
          state_d = FINISH;
        end
      end
      CHR_WR: begin
        if (wr_done) begin
          if (rom_index == 4'(ROM_LAST)) begin
            state_d = FINISH;
          end else begin
            idx_d   = rom_index + 4'd1;
            state_d = DECODE;
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = PWRUP;
    endcase
    // Only command-register clears get the long settle; a 0x01 character does not.
    req_long = req && !req_rs && (req_data == LCD_CLEAR);
    busy_d   = !(state_d == IDLE || state_d == FINISH);
    done_d   = (state_d == FINISH);
  end

endmodule

// File: tb/tb_lcd_msg_sequencer.sv
// Self-checking bench for lcd_msg_sequencer: bus monitor + write-list reference model.
module tb_lcd_msg_sequencer;

  localparam int TP  = 10;
  localparam int TE  = 2;
  localparam int TC  = 4;
  localparam int TCL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] rom_index;
  logic [8:0] rom_data;
  logic       lcd_rs, lcd_rw, lcd_e, busy, done;
  logic [7:0] lcd_data;

  logic [8:0] rom [16];
  logic [7:0] msg [11] = '{8'h41, 8'h68, 8'h6F, 8'h6A, 8'h20, 8'h50,
                           8'h56, 8'h32, 8'h30, 8'h30, 8'h21};

  assign rom_data = rom[rom_index];

  always #5 clk = ~clk;

  lcd_msg_sequencer #(
    .T_PWRUP  (TP),
    .T_EPULSE (TE),
    .T_CMD    (TC),
    .T_CLEAR  (TCL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rom_index (rom_index),
    .rom_data  (rom_data),
    .lcd_rs    (lcd_rs),
    .lcd_rw    (lcd_rw),
    .lcd_e     (lcd_e),
    .lcd_data  (lcd_data),
    .busy      (busy),
    .done      (done)
  );

  typedef struct { int cyc; logic rs; logic [7:0] data; } wr_t;
  typedef struct { logic rs; logic [7:0] data; int rel; } init_t;
  typedef struct { int term; int exp_chars; int exp_idx; } vec_t;

  wr_t   wq[$];
  wr_t   exq[$];
  wr_t   cur;
  init_t init_tab [4];
  vec_t  tab [4];

  int   cyc = 0;
  int   base = 0;
  logic e_prev = 1'b0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  logic busy_at_done = 1'b0;
  int   stab_err = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: records each E rising edge and flags RS/data changes while E is high.
  always @(negedge clk) begin
    if (lcd_e === 1'b1 && e_prev !== 1'b1) begin
      cur.cyc  = cyc;
      cur.rs   = lcd_rs;
      cur.data = lcd_data;
      wq.push_back(cur);
    end else if (lcd_e === 1'b1 && (lcd_rs !== cur.rs || lcd_data !== cur.data)) begin
      stab_err++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc     = cyc;
      busy_at_done = busy;
    end
    e_prev = lcd_e;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_rom(input int term);
    for (int i = 0; i < 16; i++)
      rom[i] = (i < term) ? {1'b1, msg[i % 11]} : 9'h000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_e",     lcd_e,     0);
    chk("rst_rs",    lcd_rs,    0);
    chk("rst_rw",    lcd_rw,    0);
    chk("rst_data",  lcd_data,  0);
    chk("rst_index", rom_index, 0);
    chk("rst_done",  done,      0);
    chk("rst_busy",  busy,      1);
    wq.delete();
    done_cnt = 0;
    stab_err = 0;
    rst  = 1'b0;
    base = cyc;
  endtask

  task automatic check_init(input bit noisy);
    int fall_rel;
    int last_rel;
    for (int k = 0; k < 300; k++) begin
      tick();
      start = 1'b0;
      if (busy === 1'b0) break;
      if (noisy && (k % 7 == 3)) start = 1'b1;
    end
    start    = 1'b0;
    fall_rel = cyc - base;
    last_rel = init_tab[3].rel;
    chk("busy_fall", fall_rel, last_rel + TE + TC);
    chk("init_count", wq.size(), 4);
    for (int i = 0; i < 4 && i < wq.size(); i++) begin
      chk("init_rs_data", {wq[i].rs, wq[i].data}, {init_tab[i].rs, init_tab[i].data});
      chk("init_cycle", wq[i].cyc - base, init_tab[i].rel);
    end
    chk("init_no_done", done_cnt, 0);
    chk("init_stable", stab_err, 0);
  endtask

  // Reference model: clear write, then characters until a terminator or 16 entries.
  task automatic build_model(input int n, output int nch, output int exp_idx, output int exp_done);
    int r;
    int settle;
    wr_t w;
    exq.delete();
    r = n + 2;
    w.cyc = r; w.rs = 1'b0; w.data = 8'h01;
    exq.push_back(w);
    settle = TCL;
    nch = 0;
    for (int i = 0; i < 16; i++) begin
      if (rom[i][8] !== 1'b1) break;
      r = r + TE + settle + 2;
      w.cyc = r; w.rs = 1'b1; w.data = rom[i][7:0];
      exq.push_back(w);
      settle = TC;
      nch++;
    end
    exp_idx  = (nch == 16) ? 15 : nch;
    exp_done = r + TE + settle + ((nch == 16) ? 0 : 1);
  endtask

  task automatic print_and_check(input bit noisy, output int nch, output int exp_idx);
    int n;
    int exp_done;
    int sz;
    wq.delete();
    done_cnt = 0;
    stab_err = 0;
    n = cyc;
    build_model(n, nch, exp_idx, exp_done);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2000; k++) begin
      if (done_cnt > 0) break;
      start = (noisy && (k % 13 == 5)) ? 1'b1 : 1'b0;
      tick();
    end
    start = 1'b0;
    if (done_cnt > 0) begin
      start = 1'b1;  // arrives in the FINISH cycle and must be dropped
      tick();
      start = 1'b0;
    end
    repeat (20) tick();
    sz = wq.size();
    chk("wr_count", sz, exq.size());
    for (int i = 0; i < sz && i < exq.size(); i++) begin
      chk("wr_rs_data", {wq[i].rs, wq[i].data}, {exq[i].rs, exq[i].data});
      chk("wr_cycle", wq[i].cyc - n, exq[i].cyc - n);
    end
    chk("rom_index", rom_index, exp_idx);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_cyc - n, exp_done - n);
    chk("busy_at_done", busy_at_done, 0);
    chk("wr_stable", stab_err, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int nch;
    int idx;

    init_tab[0] = '{1'b0, 8'h38, TP + 1};
    init_tab[1] = '{1'b0, 8'h0C, TP + 1 + (1 + TE + TC)};
    init_tab[2] = '{1'b0, 8'h01, TP + 1 + 2 * (1 + TE + TC)};
    init_tab[3] = '{1'b0, 8'h06, TP + 1 + 2 * (1 + TE + TC) + (1 + TE + TCL)};

    tab[0] = '{11, 11, 11};
    tab[1] = '{0, 0, 0};
    tab[2] = '{16, 16, 15};
    tab[3] = '{5, 5, 5};

    fill_rom(11);
    do_reset();
    check_init(1'b0);

    for (int v = 0; v < 4; v++) begin
      fill_rom(tab[v].term);
      print_and_check(1'b0, nch, idx);
      chk("tab_chars", nch, tab[v].exp_chars);
      chk("tab_index", rom_index, tab[v].exp_idx);
    end

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++)
        rom[i] = {($urandom_range(0, 7) != 0), 8'($urandom)};
      print_and_check(1'b0, nch, idx);
    end

    // start pulses during init and mid-print are dropped
    fill_rom(11);
    do_reset();
    check_init(1'b1);
    print_and_check(1'b1, nch, idx);
    chk("noisy_writes", wq.size(), 12);

    // reset while E is high mid-print
    fill_rom(11);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (lcd_e === 1'b1 && lcd_rs === 1'b1 && wq.size() >= 4) break;
    end
    chk("pre_rst_e", lcd_e, 1);
    rst = 1'b1;
    #1;
    chk("async_e",     lcd_e,     0);
    chk("async_rs",    lcd_rs,    0);
    chk("async_data",  lcd_data,  0);
    chk("async_index", rom_index, 0);
    chk("async_busy",  busy,      1);
    chk("async_done",  done,      0);
    do_reset();
    check_init(1'b0);
    print_and_check(1'b0, nch, idx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
